// File: rtl/bin_to_grey_if.sv
// bin_to_grey_if: binary input and Gray code outputs
// of the binary-to-Gray converter.
interface bin_to_grey_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] grey;
  logic [WIDTH-1:0] grey_q;
  logic [WIDTH-1:0] bin_dec;
  logic             first_q;
  logic             adjacent;
  logic             same;

  modport master (
    output bin,
    input  grey,
    input  grey_q,
    input  bin_dec,
    input  first_q,
    input  adjacent,
    input  same
  );

  modport slave (
    input  bin,
    output grey,
    output grey_q,
    output bin_dec,
    output first_q,
    output adjacent,
    output same
  );
endinterface

// File: rtl/bin_to_grey.sv
// bin_to_grey: combinational Gray encode, registered
// copy, decode back to binary and one-bit-step check.
module bin_to_grey #(
  parameter int WIDTH = 4
) (
  input logic         clk,
  input logic         rst,
  bin_to_grey_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] w_grey;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_bin_dec;
  logic [CW-1:0]    w_cnt;
  logic [WIDTH-1:0] r_grey_q;
  logic             r_first;

  assign w_grey = bus.bin ^ (bus.bin >> 1);

  // capture the Gray code; r_first marks a valid capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grey_q <= '0;
      r_first  <= 1'b0;
    end else begin
      r_grey_q <= w_grey;
      r_first  <= 1'b1;
    end
  end

  // bit i of the binary value is the XOR of Gray bits i..MSB
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    assign w_bin_dec[i] = ^(r_grey_q >> i);
  end

  assign w_diff = w_grey ^ r_grey_q;

  // population count of the changed bits
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt = w_cnt + CW'(w_diff[i]);
    end
  end

  assign bus.grey     = w_grey;
  assign bus.grey_q   = r_grey_q;
  assign bus.bin_dec  = w_bin_dec;
  assign bus.first_q  = r_first;
  assign bus.adjacent = r_first && (w_cnt == CW'(1));
  assign bus.same     = r_first && (w_diff == '0);
endmodule

// File: tb/tb_bin_to_grey.sv
// tb_bin_to_grey: directed checks of the WIDTH=4
// Gray converter with hand-computed expectations.
module tb_bin_to_grey;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  bin_to_grey_if #(.WIDTH(4)) bus ();

  bin_to_grey #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_comb_sweep();
    logic [3:0] exp_g [16];
    exp_g = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
              4'b0110, 4'b0111, 4'b0101, 4'b0100,
              4'b1100, 4'b1101, 4'b1111, 4'b1110,
              4'b1010, 4'b1011, 4'b1001, 4'b1000};
    for (int i = 0; i < 16; i++) begin
      bus.bin = 4'(i);
      #1;
      total++;
      if (bus.grey !== exp_g[i]) begin
        bad++;
        $display("FAIL sweep bin=%0d got=%b exp=%b",
                 i, bus.grey, exp_g[i]);
      end
      #9;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.bin = 4'd5;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (bus.grey !== 4'b0111 || bus.grey_q !== 4'b0000 ||
          bus.bin_dec !== 4'b0000 || bus.first_q !== 1'b0 ||
          bus.adjacent !== 1'b0 || bus.same !== 1'b0) begin
        bad++;
        $display("FAIL reset c=%0d g=%b gq=%b bd=%b f=%b a=%b s=%b exp g=0111 rest 0",
                 c, bus.grey, bus.grey_q, bus.bin_dec,
                 bus.first_q, bus.adjacent, bus.same);
      end
    end
  endtask

  task automatic test_round_trip();
    rst = 1'b0;
    bus.bin = 4'd9;
    @(negedge clk);
    total++;
    if (bus.grey_q !== 4'b1101 || bus.bin_dec !== 4'b1001 ||
        bus.first_q !== 1'b1) begin
      bad++;
      $display("FAIL round_trip gq=%b bd=%b f=%b exp 1101 1001 1",
               bus.grey_q, bus.bin_dec, bus.first_q);
    end
    total++;
    if (bus.same !== 1'b1 || bus.adjacent !== 1'b0) begin
      bad++;
      $display("FAIL hold9 same=%b adj=%b exp 1 0",
               bus.same, bus.adjacent);
    end
  endtask

  task automatic test_counting();
    logic [3:0] b;
    bus.bin = 4'd0;
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      b = 4'(k);
      bus.bin = b;
      #1;
      total++;
      if (bus.adjacent !== 1'b1 || bus.same !== 1'b0) begin
        bad++;
        $display("FAIL count bin=%0d adj=%b same=%b exp 1 0",
                 b, bus.adjacent, bus.same);
      end
      @(negedge clk);
      total++;
      if (bus.bin_dec !== b ||
          bus.grey_q !== (b ^ (b >> 1))) begin
        bad++;
        $display("FAIL count_dec bin=%0d bd=%b gq=%b",
                 b, bus.bin_dec, bus.grey_q);
      end
    end
  endtask

  task automatic test_nonadjacent();
    logic [3:0] nxt [3];
    logic       ea  [3];
    nxt = '{4'd7, 4'd11, 4'd10};
    ea  = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      bus.bin = 4'd4;
      @(negedge clk);
      bus.bin = nxt[i];
      #1;
      total++;
      if (bus.adjacent !== ea[i] || bus.same !== 1'b0) begin
        bad++;
        $display("FAIL jump 4->%0d adj=%b same=%b exp %b 0",
                 nxt[i], bus.adjacent, bus.same, ea[i]);
      end
      @(negedge clk);
    end
    bus.bin = 4'd4;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.same !== 1'b1 || bus.adjacent !== 1'b0) begin
      bad++;
      $display("FAIL hold4 same=%b adj=%b exp 1 0",
               bus.same, bus.adjacent);
    end
  endtask

  task automatic test_midrun_reset();
    bus.bin = 4'd11;
    @(negedge clk);
    bus.bin = 4'd12;
    rst = 1'b1;
    #1;
    total++;
    if (bus.grey !== 4'b1010) begin
      bad++;
      $display("FAIL mid_grey got=%b exp=1010", bus.grey);
    end
    @(negedge clk);
    total++;
    if (bus.grey !== 4'b1010 || bus.grey_q !== 4'b0000 ||
        bus.first_q !== 1'b0 || bus.bin_dec !== 4'b0000 ||
        bus.adjacent !== 1'b0 || bus.same !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset g=%b gq=%b f=%b bd=%b a=%b s=%b",
               bus.grey, bus.grey_q, bus.first_q,
               bus.bin_dec, bus.adjacent, bus.same);
    end
    rst = 1'b0;
    bus.bin = 4'd13;
    #1;
    total++;
    if (bus.adjacent !== 1'b0) begin
      bad++;
      $display("FAIL mid_adj0 adj=%b exp=0", bus.adjacent);
    end
    @(negedge clk);
    total++;
    if (bus.grey_q !== 4'b1011 || bus.first_q !== 1'b1) begin
      bad++;
      $display("FAIL mid_resume gq=%b f=%b exp 1011 1",
               bus.grey_q, bus.first_q);
    end
    bus.bin = 4'd14;
    #1;
    total++;
    if (bus.adjacent !== 1'b1) begin
      bad++;
      $display("FAIL mid_adj1 adj=%b exp=1", bus.adjacent);
    end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.bin = '0;
    test_comb_sweep();
    test_reset();
    test_round_trip();
    test_counting();
    test_nonadjacent();
    test_midrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bin_to_grey.md
Name: bin_to_grey

Overview:
Parameterised binary-to-Gray-code converter used in Gray-counter and clock-domain-crossing pointer paths. It provides:
- a zero-latency combinational Gray output;
- a registered copy of that output;
- a registered Gray-to-binary decode for self-checking;
- an adjacency flag that confirms successive codes differ in exactly one bit.

Parameters:
WIDTH, 4, bit width of the binary input and of all code outputs (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
bin  input  WIDTH  binary value to convert
grey  output  WIDTH  combinational Gray code of bin
grey_q  output  WIDTH  grey registered on clk
bin_dec  output  WIDTH  binary decode of grey_q (must equal bin as of the previous edge)
first_q  output  1  set once one post-reset sample has been captured
adjacent  output  1  current grey differs from grey_q in exactly one bit
same  output  1  current grey equals grey_q

Behaviour:
- Combinational conversion:
  - grey = bin XOR (bin >> 1), logical shift, so grey[WIDTH-1] = bin[WIDTH-1].
  - For i < WIDTH-1, grey[i] = bin[i] ^ bin[i+1].
  - Zero latency; grey follows bin in the same delta/timestep.
  - Independent of clk and rst; rst never forces grey.
- Registered stage, at each rising clk edge:
  - If rst: grey_q <= 0 and first_q <= 0.
  - Otherwise: grey_q <= grey and first_q <= 1.
  - first_q stays 1 until the next reset.
- Decode:
  - bin_dec is combinational from grey_q; no extra register.
  - bin_dec[WIDTH-1] = grey_q[WIDTH-1].
  - bin_dec[i] = bin_dec[i+1] ^ grey_q[i].
  - After reset, bin_dec = 0.
- Adjacency check, combinational:
  - diff = grey XOR grey_q.
  - adjacent = first_q AND (popcount(diff) == 1).
  - same = first_q AND (diff == 0).
  - Both are 0 while first_q is 0, including the cycle where rst is asserted, since rst clears first_q on that edge.
- Wrap-around:
  - bin stepping from all-ones to 0 gives grey 100..0 -> 000..0, so adjacent = 1.
  - Any +1 or -1 modular step of bin must yield adjacent = 1.
  - A jump of two or more counts yields adjacent = 0, except where the Gray codes happen to differ by one bit (e.g. 0 -> 3).
- Reset mid-operation: the grey output keeps tracking bin. grey_q, bin_dec, first_q, adjacent and same return to 0 on the reset edge.
- X handling: no latches; all outputs are fully defined for every defined bin.
- Width rules:
  - No arithmetic carries anywhere.
  - popcount is computed over WIDTH bits with an internal counter of at least clog2(WIDTH+1) bits.
  - The "exactly one bit" test may be implemented as diff != 0 AND (diff & (diff-1)) == 0.

Test Plan:
- Exhaustive combinational sweep, WIDTH=4, bin 0..15 every 10 ns, grey checked after settle:
  - bin 0..7 -> grey 0000,0001,0011,0010,0110,0111,0101,0100.
  - bin 8..15 -> grey 1100,1101,1111,1110,1010,1011,1001,1000.
- Reset: hold rst=1 for 2 cycles with bin=5 -> grey=0111 throughout; grey_q=0000, bin_dec=0000, first_q=0, adjacent=0, same=0.
- Registered round trip: release rst and apply bin=9 -> after the next edge, grey_q=1101, bin_dec=1001, first_q=1.
- Counting sequence: bin increments 0..15 then wraps to 0, one step per clock -> adjacent=1 on every cycle after the first post-reset capture, including the 15->0 wrap (1000 vs 0000).
- Non-adjacent and hold:
  - grey_q from bin=4 (0110), then bin=7 (0100) -> adjacent=1.
  - grey_q from bin=4, then bin=11 (1110) -> adjacent=1 (Gray codes differ in bit 3 only).
  - grey_q from bin=4, then bin=10 (1111) -> adjacent=0, same=0.
  - bin held constant -> same=1, adjacent=0.
- Mid-run reset: while counting at bin=12, assert rst for one cycle -> grey still 1010; grey_q=0 and first_q=0 after that edge; adjacent=0 on the following cycle. Counting resumes normally one cycle after release.
